// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus frame pacer that spaces tx_trig pulses one full UART frame apart.
// Define UART_TXF_OVF_STICKY_EN to add the sticky overflow flag (ovf port).
module uart_tx_fifo #(
    parameter int BAUD_CYCLES = 5208,
    parameter int FRAME_BITS  = 10,
    parameter int GAP_MARGIN  = 4,
    parameter int DEPTH       = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          sclk,
    input  logic          s_rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   fill,
    output logic          tx_trig,
    output logic [7:0]    tx_data,
    output logic          busy
`ifdef UART_TXF_OVF_STICKY_EN
    ,
    output logic          ovf
`endif
);

    localparam int GAP_END = BAUD_CYCLES * FRAME_BITS + GAP_MARGIN - 1;
    localparam int CW      = $clog2(GAP_END + 1);

    localparam logic [CW-1:0] GAP_END_C = CW'(GAP_END);
    localparam logic [CW-1:0] ONE_G     = CW'(1);
    localparam logic [AW-1:0] ONE_P     = AW'(1);
    localparam logic [AW:0]   ONE_F     = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   gap_cnt_r;
    logic [CW-1:0]   gap_cnt_nxt_s;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     fill_r;
    logic [AW:0]     fill_nxt_s;
    logic            full_r;
    logic            empty_r;
    logic            tx_trig_r;
    logic [7:0]      tx_data_r;
    logic            busy_r;
    logic [7:0]      mem_r [DEPTH];
    logic            pop_s;
    logic            push_s;

    // A full FIFO still accepts a write when the pacer pops in the same cycle.
    always_comb begin
        pop_s  = (state_r == ST_TRIG);
        push_s = wr_en && (!full_r || pop_s);
    end

    // Occupancy bookkeeping from the push/pop pair.
    always_comb begin
        fill_nxt_s = fill_r;
        case ({push_s, pop_s})
            2'b10:   fill_nxt_s = fill_r + ONE_F;
            2'b01:   fill_nxt_s = fill_r - ONE_F;
            default: fill_nxt_s = fill_r;
        endcase
    end

    // Pacer next-state: one TRIG cycle, then GAP_END+1 WAIT cycles before the next trigger.
    always_comb begin
        state_nxt_s   = state_r;
        gap_cnt_nxt_s = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    state_nxt_s = ST_TRIG;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRIG: begin
                state_nxt_s   = ST_WAIT;
                gap_cnt_nxt_s = {CW{1'b0}};
            end
            ST_WAIT: begin
                if (gap_cnt_r == GAP_END_C) begin
                    state_nxt_s = empty_r ? ST_IDLE : ST_TRIG;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + ONE_G;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                gap_cnt_nxt_s = {CW{1'b0}};
            end
        endcase
    end

    // Pacer state and its registered outputs; tx_data is loaded as TRIG is entered.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= {CW{1'b0}};
            tx_trig_r <= 1'b0;
            tx_data_r <= 8'h00;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
            tx_trig_r <= (state_nxt_s == ST_TRIG);
            busy_r    <= (state_nxt_s != ST_IDLE);
            if (state_nxt_s == ST_TRIG) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // FIFO pointers, fill counter and flags.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            fill_r   <= {(AW + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_P;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_P;
            end
            fill_r  <= fill_nxt_s;
            full_r  <= (fill_nxt_s == DEPTH_C);
            empty_r <= (fill_nxt_s == {(AW + 1){1'b0}});
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge sclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

`ifdef UART_TXF_OVF_STICKY_EN
    logic ovf_r;
    logic drop_s;

    // A write is lost only when full and no pop frees a slot that cycle.
    always_comb begin
        drop_s = wr_en && full_r && !pop_s;
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | drop_s;
        end
    end

    assign ovf = ovf_r;
`endif

    assign full    = full_r;
    assign empty   = empty_r;
    assign fill    = fill_r;
    assign tx_trig = tx_trig_r;
    assign tx_data = tx_data_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a queue-and-timing reference model predicts every trigger,
// byte and flag; a negedge monitor compares. Honours UART_TXF_OVF_STICKY_EN for the ovf port.
module tb_uart_tx_fifo;

    localparam int DEPTH   = 16;
    localparam int SPACING = 8 * 10 + 4 + 1;   // GAP_END + 2 trigger spacing

    logic       sclk    = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] fill;
    logic       tx_trig;
    logic [7:0] tx_data;
    logic       busy;
`ifdef UART_TXF_OVF_STICKY_EN
    logic       ovf;
`endif

    uart_tx_fifo #(
        .BAUD_CYCLES (8),
        .FRAME_BITS  (10),
        .GAP_MARGIN  (4),
        .DEPTH       (DEPTH)
    ) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .fill    (fill),
        .tx_trig (tx_trig),
        .tx_data (tx_data),
        .busy    (busy)
`ifdef UART_TXF_OVF_STICKY_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [7:0] d;
        int         wc;
    } ent_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    ent_t       m_q[$];
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    bit         have_last = 1'b0;
    int         last_trig = 0;
    bit         pop_cur = 1'b0;
    logic [7:0] m_txd = 8'h00;
    bit         m_ovf = 1'b0;

    task automatic check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic bit m_busy();
        return have_last && ((cyc - last_trig) < SPACING);
    endfunction

    // Reference model: a byte may leave once it has been stored for a full cycle
    // and SPACING cycles have elapsed since the previous trigger.
    initial begin
        forever begin
            @(posedge sclk);
            cyc++;
            if (!s_rst_n) begin
                m_q.delete();
                exp_q.delete();
                exp_cyc_q.delete();
                have_last = 1'b0;
                pop_cur   = 1'b0;
                m_txd     = 8'h00;
                m_ovf     = 1'b0;
            end else begin
                int   sz;
                ent_t e;
                sz = m_q.size();
                if (pop_cur) void'(m_q.pop_front());
                if (wr_en) begin
                    if (sz < DEPTH || pop_cur) begin
                        e.d  = wr_data;
                        e.wc = cyc - 1;
                        m_q.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                pop_cur = (m_q.size() > 0) && (m_q[0].wc <= cyc - 2) &&
                          (!have_last || cyc >= last_trig + SPACING);
                if (pop_cur) begin
                    have_last = 1'b1;
                    last_trig = cyc;
                    m_txd     = m_q[0].d;
                    exp_q.push_back(m_q[0].d);
                    exp_cyc_q.push_back(cyc);
                end
            end
        end
    end

    // Monitor: compare flags every cycle and pop the scoreboard on each trigger.
    initial begin
        forever begin
            @(negedge sclk);
            if (s_rst_n) begin
                check("fill", int'(fill), m_q.size());
                check("full", int'(full), int'(m_q.size() == DEPTH));
                check("empty", int'(empty), int'(m_q.size() == 0));
                check("busy", int'(busy), int'(m_busy()));
                check("tx_data_hold", int'(tx_data), int'(m_txd));
                check("tx_trig", int'(tx_trig), int'(pop_cur));
`ifdef UART_TXF_OVF_STICKY_EN
                check("ovf", int'(ovf), int'(m_ovf));
`endif
                if (tx_trig && exp_q.size() > 0) begin
                    check("trig_data", int'(tx_data), int'(exp_q.pop_front()));
                    check("trig_cycle", cyc, exp_cyc_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int t = 0;
        while ((m_q.size() > 0 || m_busy()) && t < 4000) begin
            step();
            t++;
        end
        check("drain_done", m_q.size() + int'(m_busy()), 0);
        idle(2);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_fill"}, int'(fill), 0);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_tx_trig"}, int'(tx_trig), 0);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
`ifdef UART_TXF_OVF_STICKY_EN
        check({tag, "_ovf"}, int'(ovf), 0);
`endif
    endtask

    initial begin
        // Power-on reset
        idle(2);
        @(negedge sclk);
        reset_checks("rst");
        step();
        s_rst_n = 1'b1;
        idle(3);

        // Single byte
        put(8'hA5);
        drain();

        // Back-to-back burst
        put(8'h11);
        put(8'h22);
        put(8'h33);
        drain();

        // Overflow: 17 writes while the pacer sits in WAIT
        put(8'hE0);
        idle(4);
        for (int i = 0; i < 17; i++) put(8'(8'h40 + i));
        @(negedge sclk);
        check("full_after_17", int'(full), 1);
        check("fill_after_17", int'(fill), DEPTH);
        step();
        drain();

        // Full FIFO with a write held across the TRIG cycle
        put(8'hC0);
        idle(2);
        for (int i = 0; i < 16; i++) put(8'(8'h50 + i));
        for (int i = 0; i < 100; i++) put(8'(8'h80 + i));
        drain();

        // Wrap-around with continuous refill
        for (int i = 0; i < 40; i++) begin
            int t = 0;
            while (m_q.size() >= DEPTH && t < 200) begin
                step();
                t++;
            end
            put(8'(8'h01 + i));
        end
        drain();

        // Reset in the middle of WAIT with bytes queued
        for (int i = 0; i < 6; i++) put(8'(8'hD0 + i));
        idle(20);
        s_rst_n = 1'b0;
        #2;
        reset_checks("midrst");
        idle(2);
        s_rst_n = 1'b1;
        idle(200);
        check("post_rst_fill", int'(fill), 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
